// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx serializer among N_CLIENTS byte
// producers. Multi-byte packets keep the line through a lock that is dropped
// if the owner stalls for LOCK_TIMEOUT idle clocks.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | arbitrate (owner only while locked), count lock stall
// ACCEPT | req_ready_o to granted client for one cycle, latch its byte
// SEND   | tx_ready_o high, wait for tx_valid_i (frame finished)
// GAP    | enforce inter-frame idle clocks

module uart_tx_arbiter #(
    parameter int N_CLIENTS    = 4,
    parameter int GAP_CYCLES   = 16,
    parameter int LOCK_TIMEOUT = 1024
) (
    input  logic                   clk_i,
    input  logic                   nreset_i,
    input  logic [N_CLIENTS-1:0]   req_valid_i,
    input  logic [8*N_CLIENTS-1:0] req_data_i,
    input  logic [N_CLIENTS-1:0]   req_last_i,
    output logic [N_CLIENTS-1:0]   req_ready_o,
    output logic [N_CLIENTS-1:0]   grant_o,
    output logic [7:0]             tx_data_o,
    output logic                   tx_ready_o,
    input  logic                   tx_valid_i,
    output logic                   busy_o
);

    localparam int IDX_W = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;
    localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam int TMO_W = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;

    localparam logic [IDX_W-1:0] PTR_RST  = IDX_W'(N_CLIENTS - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;
    // Last stall clock before the lock is released; compared before incrementing.
    localparam logic [TMO_W-1:0] TMO_LAST = (LOCK_TIMEOUT > 0) ? TMO_W'(LOCK_TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCEPT,
        ST_SEND,
        ST_GAP
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] gidx;
    logic             lock;
    logic [GAP_W-1:0] gap_cnt;
    logic [TMO_W-1:0] tmo_cnt;

    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;
    logic [IDX_W-1:0] cand;

    function automatic logic [N_CLIENTS-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [N_CLIENTS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Rotating search: first requester at or after ptr+1 (iterating downward so
    // the nearest candidate is the last assignment and wins).
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int i = N_CLIENTS; i >= 1; i--) begin
            cand = IDX_W'((int'(ptr) + i) % N_CLIENTS);
            if (req_valid_i[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Arbitration FSM with registered outputs, lock and counters.
    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            state       <= ST_IDLE;
            ptr         <= PTR_RST;
            gidx        <= '0;
            lock        <= 1'b0;
            gap_cnt     <= '0;
            tmo_cnt     <= '0;
            req_ready_o <= '0;
            grant_o     <= '0;
            tx_data_o   <= '0;
            tx_ready_o  <= 1'b0;
            busy_o      <= 1'b0;
        end else begin
            req_ready_o <= '0;
            case (state)
                ST_IDLE: begin
                    if (lock) begin
                        // ptr holds the owner while locked
                        if (req_valid_i[ptr]) begin
                            gidx        <= ptr;
                            grant_o     <= onehot(ptr);
                            req_ready_o <= onehot(ptr);
                            busy_o      <= 1'b1;
                            state       <= ST_ACCEPT;
                        end else if (LOCK_TIMEOUT > 0) begin
                            if (tmo_cnt >= TMO_LAST) begin
                                lock    <= 1'b0;
                                tmo_cnt <= '0;
                                grant_o <= '0;
                            end else begin
                                tmo_cnt <= tmo_cnt + 1'b1;
                            end
                        end
                    end else if (pick_found) begin
                        gidx        <= pick_idx;
                        grant_o     <= onehot(pick_idx);
                        req_ready_o <= onehot(pick_idx);
                        busy_o      <= 1'b1;
                        state       <= ST_ACCEPT;
                    end
                end
                ST_ACCEPT: begin
                    if (req_valid_i[gidx]) begin
                        tx_data_o  <= req_data_i[{gidx, 3'b000} +: 8];
                        ptr        <= gidx;
                        lock       <= !req_last_i[gidx];
                        tmo_cnt    <= '0;
                        tx_ready_o <= 1'b1;
                        state      <= ST_SEND;
                    end else begin
                        // requester withdrew: nothing transferred
                        busy_o <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end
                ST_SEND: begin
                    if (tx_valid_i) begin
                        tx_ready_o <= 1'b0;
                        if (GAP_CYCLES > 0) begin
                            gap_cnt <= GAP_LOAD;
                            state   <= ST_GAP;
                        end else begin
                            busy_o <= 1'b0;
                            state  <= ST_IDLE;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == '0) begin
                        busy_o <= 1'b0;
                        state  <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: begin
                    busy_o     <= 1'b0;
                    tx_ready_o <= 1'b0;
                    state      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
